// File: rtl/fft_pkg.sv
// Shared definitions for the FFT weight path.
//   depth_of()    : number of twiddle words for a 2^npoint-point FFT
//   load_state_t  : state encoding of the weight load controller
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } load_state_t;

  // npoint stages, each needing 2^(npoint-1) twiddle words.
  function automatic int depth_of(input int npoint);
    return npoint * (1 << (npoint - 1));
  endfunction

endpackage

// File: rtl/weight_load_ctrl.sv
// Load controller for the weight bank: FSM, word counter and length check.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_din_valid, i_din_last input handshake valid and end-of-load marker
//   i_swap_req, i_clear     commit request and synchronous load abort
//   o_din_ready             ready half of the input handshake
//   o_wr_en, o_wr_idx       shadow-bank write strobe and slot index
//   o_commit                shadow -> active copy strobe (this edge)
//   o_word_cnt              words accepted in the current load
//   o_len_err               one-cycle pulse after a length mismatch
//   o_state                 current FSM state (debug)
// Handshake: a word transfers on a rising edge where o_din_ready and
// i_din_valid are both high; o_din_ready never depends on i_din_valid.
module weight_load_ctrl
  import fft_pkg::*;
#(
  parameter int DEPTH     = 12,
  parameter int CW        = 4,
  parameter int IW        = 4,
  parameter bit AUTO_SWAP = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_din_valid,
  input  logic          i_din_last,
  input  logic          i_swap_req,
  input  logic          i_clear,
  output logic          o_din_ready,
  output logic          o_wr_en,
  output logic [IW-1:0] o_wr_idx,
  output logic          o_commit,
  output logic [CW-1:0] o_word_cnt,
  output logic          o_len_err,
  output logic [1:0]    o_state
);

  load_state_t   r_state, w_nxt_state;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic          r_len_err, w_nxt_len_err;
  logic          w_xfer;
  logic          w_at_end;

  assign w_xfer   = i_din_valid && (r_state != ST_FULL);
  assign w_at_end = (r_cnt == CW'(DEPTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_len_err <= w_nxt_len_err;
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_len_err = 1'b0;
    o_wr_en       = 1'b0;
    o_commit      = 1'b0;
    if (i_clear) begin
      // Abort wins over commit and over a transfer in the same cycle.
      w_nxt_state = ST_IDLE;
      w_nxt_cnt   = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_xfer) begin
            // A load is good only if last appears exactly on the final slot.
            if (i_din_last != w_at_end) begin
              w_nxt_len_err = 1'b1;
              w_nxt_state   = ST_IDLE;
              w_nxt_cnt     = '0;
            end else begin
              o_wr_en     = 1'b1;
              w_nxt_cnt   = r_cnt + 1'b1;
              w_nxt_state = w_at_end ? ST_FULL : ST_LOAD;
            end
          end
        end
        ST_FULL: begin
          if (AUTO_SWAP || i_swap_req) begin
            o_commit    = 1'b1;
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  assign o_din_ready = (r_state != ST_FULL);
  assign o_wr_idx    = r_cnt[IW-1:0];
  assign o_word_cnt  = r_cnt;
  assign o_len_err   = r_len_err;
  assign o_state     = r_state;

endmodule

// File: rtl/weight_bank.sv
// Double-buffered twiddle weight bank. Words are loaded into a hidden shadow
// bank and copied in one step to the active bank that drives the FFT.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   din_valid/din_ready              input handshake (transfer = both high)
//   din_real, din_imag, din_last     weight word and end-of-load marker
//   swap_req, clear                  commit request, abort of pending load
//   weight_real, weight_imag         active bank, word k at [k*WIDTH +: WIDTH]
//   word_cnt                         words accepted in the current load
//   bank_valid                       active bank holds a committed load
//   swap_done, len_err               one-cycle status pulses
//   dbg_state                        load controller state (debug)
module weight_bank
  import fft_pkg::*;
#(
  parameter int NPOINT    = 3,
  parameter int WIDTH     = 16,
  parameter int AUTO_SWAP = 0,
  localparam int DEPTH    = depth_of(NPOINT),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [WIDTH-1:0]       din_real,
  input  logic [WIDTH-1:0]       din_imag,
  input  logic                   din_last,
  input  logic                   swap_req,
  input  logic                   clear,
  output logic [DEPTH*WIDTH-1:0] weight_real,
  output logic [DEPTH*WIDTH-1:0] weight_imag,
  output logic [CW-1:0]          word_cnt,
  output logic                   bank_valid,
  output logic                   swap_done,
  output logic                   len_err,
  output logic [1:0]             dbg_state
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       r_sh_real [DEPTH];
  logic [WIDTH-1:0]       r_sh_imag [DEPTH];
  logic [DEPTH*WIDTH-1:0] r_act_real, r_act_imag;
  logic                   r_bank_valid, r_swap_done;
  logic                   w_wr_en, w_commit;
  logic [IW-1:0]          w_wr_idx;

  weight_load_ctrl #(
    .DEPTH    (DEPTH),
    .CW       (CW),
    .IW       (IW),
    .AUTO_SWAP(AUTO_SWAP != 0)
  ) u_ctrl (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_din_valid(din_valid),
    .i_din_last (din_last),
    .i_swap_req (swap_req),
    .i_clear    (clear),
    .o_din_ready(din_ready),
    .o_wr_en    (w_wr_en),
    .o_wr_idx   (w_wr_idx),
    .o_commit   (w_commit),
    .o_word_cnt (word_cnt),
    .o_len_err  (len_err),
    .o_state    (dbg_state)
  );

  // Shadow bank: indexed write, so each slot is written once per load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_sh_real[k] <= '0;
        r_sh_imag[k] <= '0;
      end
    end else if (w_wr_en) begin
      r_sh_real[w_wr_idx] <= din_real;
      r_sh_imag[w_wr_idx] <= din_imag;
    end
  end

  // Active bank only moves on a commit edge, so consumers see a stable set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_real   <= '0;
      r_act_imag   <= '0;
      r_bank_valid <= 1'b0;
      r_swap_done  <= 1'b0;
    end else begin
      r_swap_done <= w_commit;
      if (w_commit) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_act_real[k*WIDTH +: WIDTH] <= r_sh_real[k];
          r_act_imag[k*WIDTH +: WIDTH] <= r_sh_imag[k];
        end
        r_bank_valid <= 1'b1;
      end
    end
  end

  assign weight_real = r_act_real;
  assign weight_imag = r_act_imag;
  assign bank_valid  = r_bank_valid;
  assign swap_done   = r_swap_done;

endmodule

// File: tb/tb_weight_bank.sv
module tb_weight_bank;
  import fft_pkg::*;

  localparam int NPOINT = 3;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 12;
  localparam int CW     = 4;
  localparam int BW     = DEPTH * WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             din_valid, din_last, swap_req, clear;
  logic [WIDTH-1:0] din_real, din_imag;

  logic          din_ready, bank_valid, swap_done, len_err;
  logic [BW-1:0] weight_real, weight_imag;
  logic [CW-1:0] word_cnt;
  logic [1:0]    dbg_state;

  logic          a_din_ready, a_bank_valid, a_swap_done, a_len_err;
  logic [BW-1:0] a_weight_real, a_weight_imag;
  logic [CW-1:0] a_word_cnt;
  logic [1:0]    a_dbg_state;

  weight_bank #(.NPOINT(NPOINT), .WIDTH(WIDTH), .AUTO_SWAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready),
    .din_real(din_real), .din_imag(din_imag), .din_last(din_last),
    .swap_req(swap_req), .clear(clear), .weight_real(weight_real),
    .weight_imag(weight_imag), .word_cnt(word_cnt), .bank_valid(bank_valid),
    .swap_done(swap_done), .len_err(len_err), .dbg_state(dbg_state)
  );

  // Auto-commit variant shares the same stimulus.
  weight_bank #(.NPOINT(NPOINT), .WIDTH(WIDTH), .AUTO_SWAP(1)) dut_auto (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(a_din_ready),
    .din_real(din_real), .din_imag(din_imag), .din_last(din_last),
    .swap_req(swap_req), .clear(clear), .weight_real(a_weight_real),
    .weight_imag(a_weight_imag), .word_cnt(a_word_cnt), .bank_valid(a_bank_valid),
    .swap_done(a_swap_done), .len_err(a_len_err), .dbg_state(a_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]   m_real [DEPTH];
  logic [WIDTH-1:0]   m_imag [DEPTH];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Samples land 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im, input logic last);
    check("din_ready_before_xfer", din_ready, 1);
    din_valid = 1'b1;
    din_real  = re;
    din_imag  = im;
    din_last  = last;
    exp_q.push_back({re, im});
    tick();
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic load(input int n, input int last_at, input bit rnd);
    logic [WIDTH-1:0] re, im;
    for (int k = 0; k < n; k++) begin
      re = rnd ? WIDTH'($urandom_range(0, 16'hffff)) : WIDTH'(k);
      im = rnd ? WIDTH'($urandom_range(0, 16'hffff)) : WIDTH'(16'h100 + k);
      send(re, im, k == last_at);
    end
  endtask

  task automatic pop_commit();
    logic [2*WIDTH-1:0] w;
    check("queue_depth_at_commit", exp_q.size(), DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      w = exp_q.pop_front();
      m_real[k] = w[2*WIDTH-1:WIDTH];
      m_imag[k] = w[WIDTH-1:0];
    end
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      check({tag, "_real"}, weight_real[k*WIDTH +: WIDTH], m_real[k]);
      check({tag, "_imag"}, weight_imag[k*WIDTH +: WIDTH], m_imag[k]);
    end
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; din_valid = 1'b0; din_last = 1'b0; swap_req = 1'b0; clear = 1'b0;
    din_real = '0; din_imag = '0;
    for (int k = 0; k < DEPTH; k++) begin m_real[k] = '0; m_imag[k] = '0; end
    tick(); tick();
    check("rst_word_cnt", word_cnt, 0);
    check("rst_bank_valid", bank_valid, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_len_err", len_err, 0);
    check_bank("rst_bank");
    rst_n = 1'b1;
    tick();
    check("rst_din_ready", din_ready, 1);
    check("rst_state", dbg_state, ST_IDLE);

    // Ramp load with manual commit; auto variant commits on the same edge.
    load(DEPTH, DEPTH - 1, 1'b0);
    check("full_word_cnt", word_cnt, DEPTH);
    check("full_din_ready", din_ready, 0);
    check("full_state", dbg_state, ST_FULL);
    check("auto_no_early_commit", a_swap_done, 0);
    check("auto_bank_valid_pre", a_bank_valid, 0);
    do_swap();
    check("swap_done_pulse", swap_done, 1);
    check("bank_valid_set", bank_valid, 1);
    check("post_swap_cnt", word_cnt, 0);
    check("post_swap_state", dbg_state, ST_IDLE);
    check("auto_swap_done", a_swap_done, 1);
    pop_commit();
    check_bank("ramp_bank");
    check("auto_slot11_real", a_weight_real[11*WIDTH +: WIDTH], m_real[11]);
    tick();
    check("swap_done_one_cycle", swap_done, 0);

    // Early last on slot 5.
    load(6, 5, 1'b1);
    check("early_last_len_err", len_err, 1);
    check("early_last_cnt", word_cnt, 0);
    check("early_last_state", dbg_state, ST_IDLE);
    exp_q.delete();
    check_bank("early_last_bank");
    tick();
    check("len_err_one_cycle", len_err, 0);

    // Missing last on the final slot.
    load(DEPTH, -1, 1'b1);
    check("missing_last_len_err", len_err, 1);
    check("missing_last_cnt", word_cnt, 0);
    exp_q.delete();
    check_bank("missing_last_bank");
    tick();

    // Full bank held without swap while the source keeps offering words.
    load(DEPTH, DEPTH - 1, 1'b1);
    check("hold_full_cnt", word_cnt, DEPTH);
    check("auto_hold_pre", a_swap_done, 0);
    din_valid = 1'b1; din_real = 16'hdead; din_imag = 16'hbeef; din_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_din_ready", din_ready, 0);
      check("hold_word_cnt", word_cnt, DEPTH);
      check("hold_swap_done", swap_done, 0);
      check("hold_slot0_real", weight_real[WIDTH-1:0], m_real[0]);
      if (i == 0) begin
        check("auto_commit_one_after", a_swap_done, 1);
        check("auto_slot0_real", a_weight_real[WIDTH-1:0], exp_q[0][2*WIDTH-1:WIDTH]);
        check("auto_slot11_imag", a_weight_imag[11*WIDTH +: WIDTH], exp_q[11][WIDTH-1:0]);
      end
    end
    din_valid = 1'b0;
    do_swap();
    check("hold_then_swap", swap_done, 1);
    pop_commit();
    check_bank("hold_bank");
    clear = 1'b1; tick(); clear = 1'b0;

    // clear beats swap_req and auto-commit in FULL.
    load(DEPTH, DEPTH - 1, 1'b1);
    clear = 1'b1; swap_req = 1'b1;
    tick();
    clear = 1'b0; swap_req = 1'b0;
    check("clear_no_swap", swap_done, 0);
    check("clear_no_auto", a_swap_done, 0);
    check("clear_cnt", word_cnt, 0);
    check("clear_state", dbg_state, ST_IDLE);
    check("clear_din_ready", din_ready, 1);
    check("clear_bank_valid", bank_valid, 1);
    exp_q.delete();
    check_bank("clear_bank");
    tick();
    check("clear_no_late_swap", swap_done, 0);

    // clear beats a same-cycle transfer.
    load(2, -1, 1'b1);
    din_valid = 1'b1; clear = 1'b1;
    tick();
    din_valid = 1'b0; clear = 1'b0;
    check("clear_xfer_cnt", word_cnt, 0);
    exp_q.delete();

    // Reset mid-load after 7 words.
    load(7, -1, 1'b1);
    check("mid_load_cnt", word_cnt, 7);
    rst_n = 1'b0;
    #1;
    check("midrst_cnt", word_cnt, 0);
    check("midrst_bank_valid", bank_valid, 0);
    check("midrst_swap_done", swap_done, 0);
    check("midrst_len_err", len_err, 0);
    for (int k = 0; k < DEPTH; k++) begin m_real[k] = '0; m_imag[k] = '0; end
    check_bank("midrst_bank");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    load(DEPTH, DEPTH - 1, 1'b1);
    do_swap();
    check("post_rst_swap", swap_done, 1);
    pop_commit();
    check_bank("post_rst_bank");
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/weight_bank.md
WEIGHT_BANK -- requirements
Module: weight_bank

Interface
REQ-001 Parameter NPOINT, default 3, log2 of FFT size; DEPTH = NPOINT * 2^(NPOINT-1) twiddle words.
REQ-002 Parameter WIDTH, default 16, bits per real/imag component.
REQ-003 Parameter AUTO_SWAP, default 0, 1 = commit shadow bank to active bank automatically after a complete load.
REQ-004 clk  input  1  clock, all state rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 din_valid  input  1  source presents a weight word.
REQ-007 din_ready  output  1  block accepts a word; transfer = din_valid & din_ready.
REQ-008 din_real  input  WIDTH  real part of the word.
REQ-009 din_imag  input  WIDTH  imag part of the word.
REQ-010 din_last  input  1  marks final word of a load sequence.
REQ-011 swap_req  input  1  request to commit shadow to active (ignored when AUTO_SWAP=1).
REQ-012 clear  input  1  synchronous abort of an in-progress or pending load.
REQ-013 weight_real  output  DEPTH*WIDTH  active-bank real parts, word k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-014 weight_imag  output  DEPTH*WIDTH  active-bank imag parts, same packing.
REQ-015 word_cnt  output  clog2(DEPTH+1)  words accepted in current load.
REQ-016 bank_valid  output  1  active bank holds at least one committed load.
REQ-017 swap_done  output  1  one-cycle pulse in the cycle after a commit.
REQ-018 len_err  output  1  one-cycle pulse on a length mismatch.

Function
REQ-019 FSM states IDLE, LOAD, FULL; din_ready = 1 in IDLE and LOAD, 0 in FULL.
REQ-020 Transfer in IDLE or LOAD writes word_cnt slot of the shadow bank (indexed write, not shift), increments word_cnt, enters LOAD.
REQ-021 Transfer with word_cnt = DEPTH-1 and din_last = 1 enters FULL, word_cnt = DEPTH.
REQ-022 din_last = 1 on any other index, or din_last = 0 on index DEPTH-1: len_err pulses next cycle, word_cnt -> 0, state -> IDLE, active bank unchanged.
REQ-023 FULL with AUTO_SWAP=0: swap_req copies shadow to active at that edge; state -> IDLE, word_cnt -> 0, bank_valid -> 1, swap_done pulses for the following cycle.
REQ-024 FULL with AUTO_SWAP=1: commit occurs on the edge after entering FULL, identical effects to REQ-023.
REQ-025 swap_req in IDLE or LOAD has no effect.
REQ-026 clear in any state: word_cnt -> 0, state -> IDLE, shadow content discarded, active bank unchanged; clear takes priority over swap_req, auto-commit and a same-cycle transfer.
REQ-027 weight_real/imag change only on a commit edge; stable throughout loading.
REQ-028 Shadow bank contents are not observable; unwritten slots have no defined value.

Reset
REQ-029 rst_n low: state IDLE, word_cnt 0, weight_real/imag 0, shadow 0, bank_valid 0, swap_done 0, len_err 0; din_ready 1 after release.
REQ-030 Reset during LOAD or FULL discards the partial load with no commit.

Structure
REQ-031 Shared package fft_pkg holds the DEPTH function of NPOINT and the FSM state encoding.
REQ-032 One sub-module, weight_load_ctrl (FSM, word counter, length check), drives write-enable/index to the bank registers in weight_bank.

Verification (NPOINT=3, WIDTH=16, DEPTH=12)
REQ-033 Load words real=k, imag=0x100+k, k=0..11, last on k=11, then swap_req -> weight_real slot k = k, swap_done one cycle, bank_valid 1.
REQ-034 din_last on k=5 -> len_err pulse, word_cnt 0, weight outputs still 0 (or previous bank).
REQ-035 Load 12 words, hold swap_req low 10 cycles with din_valid high -> din_ready 0, no outputs change; then swap_req -> commit.
REQ-036 AUTO_SWAP=1, full load -> commit exactly one cycle after last transfer, no swap_req needed.
REQ-037 clear asserted with swap_req in FULL -> no commit, state IDLE, old active bank retained.
REQ-038 rst_n low mid-load after 7 words -> all outputs 0, next full load commits correctly.
